// File: rtl/eeprom_verify_seq.sv
// eeprom_verify_seq
//   Command sequencer sitting directly upstream of iic_com. A run writes
//   NUM_BYTES bytes (DATA_SEED+idx) starting at BASE_ADDR, waits tWR after
//   each write, then reads every byte back and compares it with the pattern.
//   The first mismatch stops the run and is reported on Err_Addr/Err_Data.
//
// Ports
//   CLK        system clock (50 MHz)
//   RSTn       asynchronous active-low reset (shared with iic_com)
//   Go         run request, level sampled each cycle while idle/done
//   Start_Sig  to iic_com: 2'b01 write, 2'b10 read, 2'b00 idle
//   Addr_Sig   to iic_com: EEPROM word address
//   WrData     to iic_com: write byte
//   RdData     from iic_com: read byte, valid in the Done_Sig cycle
//   Done_Sig   from iic_com: one-cycle transaction-complete pulse
//   Busy       high from run start until DONE is entered
//   Pass       sticky: every byte matched
//   Fail       sticky: a mismatch was found
//   Err_Addr   address of the first mismatch
//   Err_Data   RdData at the first mismatch
//   LED        {rd_phase, Fail, Pass, Busy}
module eeprom_verify_seq #(
  parameter int unsigned NUM_BYTES = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [7:0]  DATA_SEED = 8'h12,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TWR_US    = 5000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Go,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Done_Sig,
  output logic       Busy,
  output logic       Pass,
  output logic       Fail,
  output logic [7:0] Err_Addr,
  output logic [7:0] Err_Data,
  output logic [3:0] LED
);

  localparam logic [31:0] TWR_CYC  = 32'((CLK_HZ / 1_000_000) * TWR_US);
  // The wait state lasts TWR_CYC cycles: the counter runs TWR_CYC-1 down to 0.
  localparam logic [31:0] TWR_LOAD = (TWR_CYC == 32'd0) ? '0 : TWR_CYC - 32'd1;
  localparam logic [8:0]  LAST_IDX = 9'(NUM_BYTES - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_TWR_WAIT,
    S_RD_REQ,
    S_RD_GAP,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  idx, idx_nxt;
  logic [31:0] wait_cnt, wait_cnt_nxt;
  logic        rd_phase, rd_phase_nxt;

  logic [1:0]  start_nxt;
  logic [7:0]  addr_nxt, wrdata_nxt, err_addr_nxt, err_data_nxt;
  logic        busy_nxt, pass_nxt, fail_nxt;

  logic [8:0]  idx_inc;
  logic [7:0]  cur_pattern;
  logic [7:0]  inc_addr, inc_pattern;

  assign idx_inc     = idx + 9'd1;
  assign cur_pattern = DATA_SEED + idx[7:0];
  assign inc_addr    = BASE_ADDR + idx_inc[7:0];
  assign inc_pattern = DATA_SEED + idx_inc[7:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      rd_phase  <= 1'b0;
      Start_Sig <= CMD_IDLE;
      Addr_Sig  <= '0;
      WrData    <= '0;
      Busy      <= 1'b0;
      Pass      <= 1'b0;
      Fail      <= 1'b0;
      Err_Addr  <= '0;
      Err_Data  <= '0;
      LED       <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      wait_cnt  <= wait_cnt_nxt;
      rd_phase  <= rd_phase_nxt;
      Start_Sig <= start_nxt;
      Addr_Sig  <= addr_nxt;
      WrData    <= wrdata_nxt;
      Busy      <= busy_nxt;
      Pass      <= pass_nxt;
      Fail      <= fail_nxt;
      Err_Addr  <= err_addr_nxt;
      Err_Data  <= err_data_nxt;
      LED       <= {rd_phase_nxt, fail_nxt, pass_nxt, busy_nxt};
    end
  end

  // Outputs are computed one cycle ahead so that every request appears on
  // the registered Start_Sig/Addr_Sig/WrData together with its state.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wait_cnt_nxt = wait_cnt;
    rd_phase_nxt = rd_phase;
    start_nxt    = Start_Sig;
    addr_nxt     = Addr_Sig;
    wrdata_nxt   = WrData;
    busy_nxt     = Busy;
    pass_nxt     = Pass;
    fail_nxt     = Fail;
    err_addr_nxt = Err_Addr;
    err_data_nxt = Err_Data;

    case (state)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_nxt    = S_WR_REQ;
          idx_nxt      = '0;
          rd_phase_nxt = 1'b0;
          busy_nxt     = 1'b1;
          pass_nxt     = 1'b0;
          fail_nxt     = 1'b0;
          err_addr_nxt = '0;
          err_data_nxt = '0;
          start_nxt    = CMD_WRITE;
          addr_nxt     = BASE_ADDR;
          wrdata_nxt   = DATA_SEED;
        end
      end

      S_WR_REQ: begin
        if (Done_Sig) begin
          start_nxt    = CMD_IDLE;
          wait_cnt_nxt = TWR_LOAD;
          state_nxt    = S_TWR_WAIT;
        end
      end

      S_TWR_WAIT: begin
        if (wait_cnt == 32'd0) begin
          if (idx == LAST_IDX) begin
            idx_nxt      = '0;
            rd_phase_nxt = 1'b1;
            start_nxt    = CMD_READ;
            addr_nxt     = BASE_ADDR;
            state_nxt    = S_RD_REQ;
          end else begin
            idx_nxt    = idx_inc;
            start_nxt  = CMD_WRITE;
            addr_nxt   = inc_addr;
            wrdata_nxt = inc_pattern;
            state_nxt  = S_WR_REQ;
          end
        end else begin
          wait_cnt_nxt = wait_cnt - 32'd1;
        end
      end

      S_RD_REQ: begin
        if (Done_Sig) begin
          start_nxt = CMD_IDLE;
          if (RdData != cur_pattern) begin
            fail_nxt     = 1'b1;
            err_addr_nxt = Addr_Sig;
            err_data_nxt = RdData;
            busy_nxt     = 1'b0;
            state_nxt    = S_DONE;
          end else if (idx == LAST_IDX) begin
            pass_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx_inc;
            state_nxt = S_RD_GAP;
          end
        end
      end

      // Single idle cycle so iic_com sees Start_Sig low and re-arms.
      S_RD_GAP: begin
        start_nxt = CMD_READ;
        addr_nxt  = BASE_ADDR + idx[7:0];
        state_nxt = S_RD_REQ;
      end

      default: begin
        state_nxt = S_IDLE;
        start_nxt = CMD_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
